// File: rtl/display_scan_n.sv
// display_scan_n -- multiplexed 7-segment display scanner.
//
// Scans DIGITS hex digits, one slot of 2**SCAN_LOG2 clocks per digit. Per-digit
// data is captured at the start of each slot. Brightness is set by a PWM duty
// taken from the top LUM_BITS of the slot counter. The last cycle of every slot
// is a dark guard cycle.
//
// Optional feature: define DISPLAY_SCAN_BLINK_EN to enable per-digit blinking.
// Blinking is driven by a BLINK_LOG2-bit frame counter. Without the macro, the
// blink port is ignored.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          display enable; 0 holds the scan at digit 0 / slot 0, dark
//   luminance   duty code (all ones = fully on except guard cycle)
//   hexx        hex nibble per digit, digit i = hexx[4i+3:4i]
//   points      decimal point per digit
//   blink       per-digit blink request
//   blank_lz    leading-zero blanking enable
//   segments    {a,b,c,d,e,f,g,dp}, registered
//   digits      one-hot digit enable, registered
//   frame_tick  one-cycle pulse on the last cycle of each full frame
module display_scan_n #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned SCAN_LOG2      = 10,
   parameter int unsigned LUM_BITS       = 4,
   parameter int unsigned BLINK_LOG2     = 8,
   parameter int unsigned SEG_ACTIVE_LOW = 0,
   parameter int unsigned DIG_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [LUM_BITS-1:0]   luminance,
   input  logic [4*DIGITS-1:0]   hexx,
   input  logic [DIGITS-1:0]     points,
   input  logic [DIGITS-1:0]     blink,
   input  logic                  blank_lz,
   output logic [7:0]            segments,
   output logic [DIGITS-1:0]     digits,
   output logic                  frame_tick
);

   localparam int unsigned       IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_INV  = {8{SEG_ACTIVE_LOW != 0}};
   localparam logic [DIGITS-1:0] DIG_INV  = {DIGITS{DIG_ACTIVE_LOW != 0}};

   logic [SCAN_LOG2-1:0] slot;
   logic [IDX_W-1:0]     idx;
   logic                 slot_first;
   logic                 slot_last;

   logic [3:0]           live_nib, s_nib, cur_nib;
   logic                 live_dp, s_dp, cur_dp;
   logic                 live_blank, s_blank, cur_blank;
   logic [LUM_BITS-1:0]  s_lum, cur_lum;
   logic                 upper_nz;
   logic [LUM_BITS-1:0]  phase;
   logic                 blink_dark;
   logic                 lit;
   logic [7:0]           seg_raw;
   logic [DIGITS-1:0]    dig_raw;

   function automatic logic [6:0] font7(input logic [3:0] n);
      case (n)
         4'h0: font7 = 7'b1111110;
         4'h1: font7 = 7'b0110000;
         4'h2: font7 = 7'b1101101;
         4'h3: font7 = 7'b1111001;
         4'h4: font7 = 7'b0110011;
         4'h5: font7 = 7'b1011011;
         4'h6: font7 = 7'b1011111;
         4'h7: font7 = 7'b1110000;
         4'h8: font7 = 7'b1111111;
         4'h9: font7 = 7'b1111011;
         4'hA: font7 = 7'b1110111;
         4'hB: font7 = 7'b0011111;
         4'hC: font7 = 7'b1001110;
         4'hD: font7 = 7'b0111101;
         4'hE: font7 = 7'b1001111;
         default: font7 = 7'b1000111;
      endcase
   endfunction

   assign slot_first = (slot == '0);
   assign slot_last  = &slot;
   assign frame_tick = en && slot_last && (idx == LAST_IDX);

   // Slot counter and digit index; both pinned to zero while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
         idx  <= '0;
      end else if (!en) begin
         slot <= '0;
         idx  <= '0;
      end else begin
         slot <= slot + 1'b1;
         if (slot_last)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
   end

`ifdef DISPLAY_SCAN_BLINK_EN
   logic                  live_blink, s_blink, cur_blink;
   logic [BLINK_LOG2-1:0] frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_cnt <= '0;
      else if (frame_tick)
         frame_cnt <= frame_cnt + 1'b1;
   end
`else
   logic unused_blink;
   assign unused_blink = ^blink;
`endif

   // Select the current digit's inputs and detect a non-zero nibble at or above it.
   always_comb begin
      live_nib = '0;
      live_dp  = 1'b0;
      upper_nz = 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
      live_blink = 1'b0;
`endif
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (idx == IDX_W'(j)) begin
            live_nib = hexx[4*j +: 4];
            live_dp  = points[j];
`ifdef DISPLAY_SCAN_BLINK_EN
            live_blink = blink[j];
`endif
         end
         if (j >= 32'(idx) && hexx[4*j +: 4] != 4'h0)
            upper_nz = 1'b1;
      end
      live_blank = blank_lz && (idx != '0) && !upper_nz;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_nib   <= '0;
         s_dp    <= 1'b0;
         s_blank <= 1'b0;
         s_lum   <= '0;
`ifdef DISPLAY_SCAN_BLINK_EN
         s_blink <= 1'b0;
`endif
      end else if (en && slot_first) begin
         s_nib   <= live_nib;
         s_dp    <= live_dp;
         s_blank <= live_blank;
         s_lum   <= luminance;
`ifdef DISPLAY_SCAN_BLINK_EN
         s_blink <= live_blink;
`endif
      end
   end

   // On the first cycle of a slot the sample registers still hold the previous
   // digit, so the live inputs are used directly; they are the values captured.
   assign cur_nib   = slot_first ? live_nib   : s_nib;
   assign cur_dp    = slot_first ? live_dp    : s_dp;
   assign cur_blank = slot_first ? live_blank : s_blank;
   assign cur_lum   = slot_first ? luminance  : s_lum;
`ifdef DISPLAY_SCAN_BLINK_EN
   assign cur_blink  = slot_first ? live_blink : s_blink;
   assign blink_dark = cur_blink && frame_cnt[BLINK_LOG2-1];
`else
   assign blink_dark = 1'b0;
`endif

   assign phase = slot[SCAN_LOG2-1 -: LUM_BITS];
   assign lit   = en && !slot_last && !blink_dark && ((&cur_lum) || (phase < cur_lum));

   always_comb begin
      seg_raw = '0;
      dig_raw = '0;
      if (lit) begin
         seg_raw = {cur_blank ? 7'b0000000 : font7(cur_nib), cur_dp};
         for (int unsigned j = 0; j < DIGITS; j++)
            if (idx == IDX_W'(j))
               dig_raw[j] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments <= SEG_INV;
         digits   <= DIG_INV;
      end else begin
         segments <= seg_raw ^ SEG_INV;
         digits   <= dig_raw ^ DIG_INV;
      end
   end

endmodule
